cam_bit_deserializer: RTL and testbench
=======================================

# cam_bit_deserializer

Captures the 1-bit serial camera stream `i_cam_data` while the NICE accelerator signals readiness. It packs the bits into 32-bit words and buffers them in a small FIFO. It sits between the SoC camera input pin and the NICE core (`e203_subsys_nice_core`), which drains words through a valid/ready handshake and gets frame-boundary and overflow status.

## Interface
Parameters:
- `FRAME_BITS`, 15440: serial bits per frame, legal range 32..16383.
- `FIFO_DEPTH`, 4: word FIFO entries, power of two, at least 2.

Ports:
- `clk`  in  1: core clock (hfclk domain); `i_cam_data` is synchronous to it.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: capture enable, driven by NICE `asl_ready`.
- `i_cam_data`  in  1: serial pixel bit, one bit per clk while `en`=1.
- `o_word_valid`  out  1: FIFO head is valid.
- `o_word_data`  out  32: FIFO head word; the first-captured bit is at [0].
- `o_word_last`  out  1: head word is the final word of a frame.
- `i_word_ready`  in  1: consumer pops the head when valid&ready.
- `o_frame_done`  out  1: one-cycle pulse when the last bit of a frame is sampled.
- `o_abort`  out  1: one-cycle pulse when `en` drops mid-frame.
- `o_ovf`  out  1: sticky flag, set when a word is dropped because the FIFO is full.
- `i_ovf_clr`  in  1: clears `o_ovf`; set wins if both happen in the same cycle.
- `o_bit_cnt`  out  14: index of the next bit to sample within the frame.

## Operation
State machine:
- States are IDLE and CAPTURE.
- IDLE → CAPTURE when `en`=1. The first bit is sampled in that same cycle.
- In CAPTURE, each cycle with `en`=1 samples `i_cam_data` into pack bit `bit_cnt[4:0]` and increments `bit_cnt`.

Word completion:
- A word completes when `bit_cnt[4:0]`=31 or `bit_cnt`=FRAME_BITS-1.
- The completed word (pack register merged with the current bit, unused upper bits zero) is pushed.
- `last`=1 when `bit_cnt`=FRAME_BITS-1.

End of frame:
- `bit_cnt` wraps to 0 and `o_frame_done` pulses.
- The FSM stays in CAPTURE while `en`=1, so frames are back-to-back with no gap cycle.
- With the default FRAME_BITS, a frame is 483 words and the last word holds 16 valid bits in [15:0].

`en` falling in CAPTURE before the last bit:
- The partial pack is discarded and nothing is pushed.
- `bit_cnt` returns to 0, `o_abort` pulses and the FSM goes to IDLE.
- Words already in the FIFO are kept.

FIFO:
- A push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
- Otherwise the word is dropped and `o_ovf` is set.
- A dropped `last` word is not re-sent.
- `o_frame_done` still pulses when the last word is dropped.
- Pop = `o_word_valid & i_word_ready`.

## Timing
- Reset values: FSM=IDLE, `bit_cnt`=0, pack=0, FIFO empty, `o_word_valid`=0, `o_word_data`=0, `o_word_last`=0, `o_frame_done`=0, `o_abort`=0, `o_ovf`=0.
- Reset mid-frame discards all captured data immediately (asynchronous).
- Latency: a word completed at rising edge N appears on `o_word_valid` in the cycle after N (one-cycle latency when the FIFO was empty).
- `o_frame_done` and `o_abort` are registered and high for exactly the cycle after edge N.
- Throughput is one bit per clk. The FIFO never back-pressures the serial input; data is dropped instead.
- Simultaneous push and pop at full: both occur, count is unchanged, no overflow.
- Simultaneous push and pop at empty: the pushed word becomes visible the next cycle (no bypass).
- `o_word_data` and `o_word_last` are stable while `o_word_valid`=1 and `i_word_ready`=0.

## Structure
- A shared package `cam_pkg` holds:
  - `CAM_WORD_W`=32;
  - the state encoding (IDLE=1'b0, CAPTURE=1'b1);
  - the derived `CAM_WORDS_PER_FRAME`=ceil(FRAME_BITS/32).
- One sub-module: `cam_word_fifo`, a synchronous FIFO of {last, data[31:0]} with push/pop/full/empty/count and an async active-low reset.
- The top level contains the FSM, bit counter, pack register and status flags.

## Test plan
- Basic word: `en`=1, feed 32 bits 0xA5A5_A5A5 LSB-first, `i_word_ready`=1 → a single valid with data 0xA5A5A5A5, `last`=0, one cycle after the 32nd bit.
- Full frame: FRAME_BITS=15440, random bits, consumer always ready → 483 words matching a reference pack; only word 483 has `last`=1 with data[31:16]=0; `o_frame_done` pulses once; `o_bit_cnt` returns to 0.
- Back-to-back frames: hold `en` for 2×15440 cycles → 966 words; bit 0 of frame 2 is at [0] of word 484; there is no gap cycle.
- Abort: drop `en` after 40 bits → one word pushed (the first 32 bits), `o_abort` pulses, bits 32..39 are discarded; re-enable → capture restarts at `bit_cnt`=0.
- Overflow: `i_word_ready`=0 for 6 words with FIFO_DEPTH=4 → 4 words held, `o_ovf`=1 after word 5; releasing ready drains exactly the first 4 words in order; `i_ovf_clr` clears the flag.
- Reset mid-frame: assert `rst_n`=0 after 100 bits with the FIFO non-empty → all outputs go to reset values asynchronously and no stale word appears after reset.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants, state encoding and FIFO entry type for the camera bit deserializer.
package cam_pkg;

   localparam int unsigned CAM_WORD_W          = 32;
   localparam int unsigned CAM_CNT_W           = 14;
   localparam int unsigned CAM_FRAME_BITS_DFLT = 15440;
   localparam int unsigned CAM_WORDS_PER_FRAME =
      (CAM_FRAME_BITS_DFLT + CAM_WORD_W - 1) / CAM_WORD_W;

   typedef enum logic {
      StIdle    = 1'b0,
      StCapture = 1'b1
   } cam_state_e;

   typedef struct packed {
      logic                  last;
      logic [CAM_WORD_W-1:0] data;
   } cam_word_t;

endpackage

// File: rtl/cam_word_fifo.sv
// Small synchronous FIFO of {last, data} words; a push into a full FIFO is accepted only
// when a pop happens in the same cycle. No read bypass: a pushed word is visible next cycle.
module cam_word_fifo
   import cam_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  cam_word_t              wdata_i,
   input  logic                   pop_i,
   output cam_word_t              rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   cam_word_t           mem_q [Depth];
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic                push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Head forced to zero when empty so idle outputs match the reset values.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/cam_bit_deserializer.sv
// Packs the 1-bit camera stream into 32-bit words (first bit at [0]) and queues them for the
// NICE core, flagging frame ends, aborted frames and words dropped on a full FIFO.
module cam_bit_deserializer
   import cam_pkg::*;
#(
   parameter int unsigned FRAME_BITS = 15440,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  i_cam_data,
   output logic                  o_word_valid,
   output logic [CAM_WORD_W-1:0] o_word_data,
   output logic                  o_word_last,
   input  logic                  i_word_ready,
   output logic                  o_frame_done,
   output logic                  o_abort,
   output logic                  o_ovf,
   input  logic                  i_ovf_clr,
   output logic [CAM_CNT_W-1:0]  o_bit_cnt
);

   localparam int unsigned          FifoCntW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CAM_CNT_W-1:0] LastIdx  = CAM_CNT_W'(FRAME_BITS - 1);

   cam_state_e             state_q, state_d;
   logic [CAM_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CAM_WORD_W-1:0]  pack_q, pack_d;
   logic                   frame_done_q, frame_done_d;
   logic                   abort_q, abort_d;
   logic                   ovf_q, ovf_d;

   logic                   sample;
   logic                   push;
   logic                   pop;
   logic                   is_last;
   logic [4:0]             bit_idx;
   logic [CAM_WORD_W-1:0]  cur_word;
   cam_word_t              push_word;
   cam_word_t              head_word;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [FifoCntW-1:0]    fifo_cnt;

   assign bit_idx  = bit_cnt_q[4:0];
   assign is_last  = (bit_cnt_q == LastIdx);
   assign cur_word = pack_q | (CAM_WORD_W'(i_cam_data) << bit_idx);

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      pack_d       = pack_q;
      frame_done_d = 1'b0;
      abort_d      = 1'b0;
      sample       = 1'b0;
      push         = 1'b0;
      push_word    = '0;

      unique case (state_q)
         StIdle: begin
            if (en) begin
               state_d = StCapture;
               sample  = 1'b1;
            end
         end
         StCapture: begin
            if (en) begin
               sample = 1'b1;
            end else begin
               // Dropping en right after a frame end is not an abort: nothing was captured.
               state_d   = StIdle;
               bit_cnt_d = '0;
               pack_d    = '0;
               abort_d   = (bit_cnt_q != '0);
            end
         end
         default: state_d = StIdle;
      endcase

      if (sample) begin
         if ((bit_idx == 5'd31) || is_last) begin
            push           = 1'b1;
            push_word.data = cur_word;
            push_word.last = is_last;
            pack_d         = '0;
         end else begin
            pack_d = cur_word;
         end
         if (is_last) begin
            bit_cnt_d    = '0;
            frame_done_d = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + CAM_CNT_W'(1);
         end
      end
   end

   assign pop = o_word_valid && i_word_ready;

   // Set wins over clear.
   always_comb begin
      ovf_d = ovf_q;
      if (i_ovf_clr) ovf_d = 1'b0;
      if (push && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         pack_q       <= '0;
         frame_done_q <= 1'b0;
         abort_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         pack_q       <= pack_d;
         frame_done_q <= frame_done_d;
         abort_q      <= abort_d;
         ovf_q        <= ovf_d;
      end
   end

   cam_word_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (push_word),
      .pop_i   (pop),
      .rdata_o (head_word),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   fifo_full_matches_count : assert property (@(posedge clk) disable iff (!rst_n)
      fifo_full == (fifo_cnt == FifoCntW'(FIFO_DEPTH)));

   assign o_word_valid = !fifo_empty;
   assign o_word_data  = head_word.data;
   assign o_word_last  = head_word.last;
   assign o_frame_done = frame_done_q;
   assign o_abort      = abort_q;
   assign o_ovf        = ovf_q;
   assign o_bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_cam_bit_deserializer.sv
// Randomized self-checking bench: popped words are compared with words packed from a queue
// of driven bits using the frame/word arithmetic of the deserializer's contract.
module tb_cam_bit_deserializer;

   localparam int unsigned FB  = 15440;
   localparam int unsigned WPF = (FB + 31) / 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        i_cam_data = 1'b0;
   logic        i_word_ready = 1'b0;
   logic        i_ovf_clr = 1'b0;
   logic        o_word_valid;
   logic [31:0] o_word_data;
   logic        o_word_last;
   logic        o_frame_done;
   logic        o_abort;
   logic        o_ovf;
   logic [13:0] o_bit_cnt;

   int errors = 0;
   int checks = 0;

   logic [32:0] obs_q[$];
   int          fd_cnt = 0;
   int          ab_cnt = 0;
   bit          ref_bits[$];

   always #5 clk = ~clk;

   cam_bit_deserializer #(
      .FRAME_BITS (FB),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .i_cam_data   (i_cam_data),
      .o_word_valid (o_word_valid),
      .o_word_data  (o_word_data),
      .o_word_last  (o_word_last),
      .i_word_ready (i_word_ready),
      .o_frame_done (o_frame_done),
      .o_abort      (o_abort),
      .o_ovf        (o_ovf),
      .i_ovf_clr    (i_ovf_clr),
      .o_bit_cnt    (o_bit_cnt)
   );

   // Record every pop and pulse on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_word_valid && i_word_ready) obs_q.push_back({o_word_last, o_word_data});
         if (o_frame_done) fd_cnt++;
         if (o_abort) ab_cnt++;
      end
   end

   // Word k of a stream of back-to-back frames held in ref_bits.
   function automatic logic [32:0] exp_word(int k);
      int f = k / WPF;
      int j = k % WPF;
      int base = f * FB + j * 32;
      int n = (j == WPF - 1) ? FB - 32 * j : 32;
      logic [32:0] w = '0;
      for (int i = 0; i < n; i++) w[i] = ref_bits[base + i];
      w[32] = (j == WPF - 1);
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      en = 1'b1;
      i_cam_data = b;
      step();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      en = 1'b0;
      i_cam_data = 1'b0;
      i_word_ready = 1'b0;
      i_ovf_clr = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      obs_q.delete();
      ref_bits.delete();
      fd_cnt = 0;
      ab_cnt = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (o_word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_word_valid); end
      checks++; if (o_word_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_word_data); end
      checks++; if (o_word_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", o_word_last); end
      checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", o_frame_done); end
      checks++; if (o_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", o_abort); end
      checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", o_ovf); end
      checks++; if (o_bit_cnt !== 14'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", o_bit_cnt); end
   endtask

   task automatic test_basic_word();
      logic [31:0] pat = 32'hA5A5_A5A5;
      apply_reset();
      i_word_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         drive_bit(pat[i]);
         if (i == 30) begin
            checks++; if (o_word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", o_word_valid); end
         end
      end
      en = 1'b0;
      checks++; if (o_word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", o_word_valid); end
      checks++; if (o_word_data !== pat) begin errors++; $display("FAIL basic_data got=%h exp=%h", o_word_data, pat); end
      checks++; if (o_word_last !== 1'b0) begin errors++; $display("FAIL basic_last got=%b exp=0", o_word_last); end
      checks++; if (o_bit_cnt !== 14'd32) begin errors++; $display("FAIL basic_bit_cnt got=%0d exp=32", o_bit_cnt); end
      step();
      checks++; if (o_word_valid !== 1'b0) begin errors++; $display("FAIL basic_popped got=%b exp=0", o_word_valid); end
      step();
      checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", obs_q.size()); end
   endtask

   task automatic test_frames(input int nframes);
      bit b;
      int nwords = nframes * WPF;
      apply_reset();
      i_word_ready = 1'b1;
      for (int i = 0; i < nframes * FB; i++) begin
         b = 1'($urandom);
         ref_bits.push_back(b);
         drive_bit(b);
         if ((i % FB) == FB - 1) begin
            checks++; if (o_frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse bit=%0d got=%b exp=1", i, o_frame_done); end
            checks++; if (o_bit_cnt !== 14'd0) begin errors++; $display("FAIL frame_bit_cnt_wrap bit=%0d got=%0d exp=0", i, o_bit_cnt); end
            checks++; if (!(o_word_valid === 1'b1 && o_word_last === 1'b1)) begin errors++; $display("FAIL frame_last_head valid=%b last=%b exp=1/1", o_word_valid, o_word_last); end
         end
         if (i == FB) begin
            checks++; if (o_bit_cnt !== 14'd1) begin errors++; $display("FAIL frame_no_gap got=%0d exp=1", o_bit_cnt); end
         end
      end
      en = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++; if (fd_cnt != nframes) begin errors++; $display("FAIL frame_done_count got=%0d exp=%0d", fd_cnt, nframes); end
      checks++; if (ab_cnt != 0) begin errors++; $display("FAIL frame_abort_count got=%0d exp=0", ab_cnt); end
      checks++; if (obs_q.size() != nwords) begin errors++; $display("FAIL frame_word_count got=%0d exp=%0d", obs_q.size(), nwords); end
      for (int k = 0; k < nwords && k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_word(k)) begin
            errors++;
            $display("FAIL frame_word k=%0d got=%h exp=%h", k, obs_q[k], exp_word(k));
         end
      end
      if (nframes > 1 && obs_q.size() > WPF) begin
         checks++; if (obs_q[WPF][0] !== ref_bits[FB]) begin errors++; $display("FAIL frame2_bit0 got=%b exp=%b", obs_q[WPF][0], ref_bits[FB]); end
      end
   endtask

   task automatic test_abort();
      bit b;
      apply_reset();
      i_word_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         b = 1'($urandom);
         ref_bits.push_back(b);
         drive_bit(b);
      end
      en = 1'b0;
      checks++; if (o_abort !== 1'b0) begin errors++; $display("FAIL abort_early got=%b exp=0", o_abort); end
      step();
      checks++; if (o_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse got=%b exp=1", o_abort); end
      checks++; if (o_bit_cnt !== 14'd0) begin errors++; $display("FAIL abort_bit_cnt got=%0d exp=0", o_bit_cnt); end
      step();
      checks++; if (o_abort !== 1'b0) begin errors++; $display("FAIL abort_one_cycle got=%b exp=0", o_abort); end
      step();
      checks++; if (ab_cnt != 1) begin errors++; $display("FAIL abort_count got=%0d exp=1", ab_cnt); end
      checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL abort_words got=%0d exp=1", obs_q.size()); end
      if (obs_q.size() >= 1) begin
         checks++; if (obs_q[0] !== exp_word(0)) begin errors++; $display("FAIL abort_word0 got=%h exp=%h", obs_q[0], exp_word(0)); end
      end
      ref_bits.delete();
      for (int i = 0; i < 32; i++) begin
         b = 1'($urandom);
         ref_bits.push_back(b);
         drive_bit(b);
         if (i == 0) begin
            checks++; if (o_bit_cnt !== 14'd1) begin errors++; $display("FAIL abort_restart_cnt got=%0d exp=1", o_bit_cnt); end
         end
      end
      en = 1'b0;
      step();
      step();
      checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL abort_restart_words got=%0d exp=2", obs_q.size()); end
      if (obs_q.size() >= 2) begin
         checks++; if (obs_q[1] !== exp_word(0)) begin errors++; $display("FAIL abort_restart_word got=%h exp=%h", obs_q[1], exp_word(0)); end
      end
   endtask

   task automatic test_overflow();
      bit b;
      apply_reset();
      i_word_ready = 1'b0;
      for (int i = 0; i < 192; i++) begin
         b = 1'($urandom);
         ref_bits.push_back(b);
         drive_bit(b);
         if (i == 127) begin
            checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", o_ovf); end
         end
         if (i == 159) begin
            checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", o_ovf); end
         end
      end
      en = 1'b0;
      step();
      i_word_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      i_word_ready = 1'b0;
      checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL ovf_drain_count got=%0d exp=4", obs_q.size()); end
      for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_word(k)) begin
            errors++;
            $display("FAIL ovf_word k=%0d got=%h exp=%h", k, obs_q[k], exp_word(k));
         end
      end
      checks++; if (o_word_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", o_word_valid); end
      checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", o_ovf); end
      i_ovf_clr = 1'b1;
      step();
      i_ovf_clr = 1'b0;
      checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", o_ovf); end
   endtask

   task automatic test_reset_mid_frame();
      bit b;
      apply_reset();
      i_word_ready = 1'b0;
      for (int i = 0; i < 100; i++) drive_bit(1'($urandom));
      checks++; if (o_word_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b exp=1", o_word_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (o_word_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", o_word_valid); end
      checks++; if (o_word_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", o_word_data); end
      checks++; if (o_bit_cnt !== 14'd0) begin errors++; $display("FAIL rstmid_bit_cnt got=%0d exp=0", o_bit_cnt); end
      en = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      i_word_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_stale got=%0d exp=0", obs_q.size()); end
      ref_bits.delete();
      for (int i = 0; i < 32; i++) begin
         b = 1'($urandom);
         ref_bits.push_back(b);
         drive_bit(b);
      end
      en = 1'b0;
      step();
      step();
      checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rstmid_after_count got=%0d exp=1", obs_q.size()); end
      if (obs_q.size() >= 1) begin
         checks++; if (obs_q[0] !== exp_word(0)) begin errors++; $display("FAIL rstmid_after_word got=%h exp=%h", obs_q[0], exp_word(0)); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_word();
      test_frames(1);
      test_frames(2);
      test_abort();
      test_overflow();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
